// File: rtl/i2c_regbank_arb.sv
// Register bank shared by the I2C slave application bus and a local core port; one storage access per clock.
// Latency: I2C write commits at its strobe edge, prefetch refreshes at the next free edge, core access 0-2 cycles, core read data +1 cycle.
// Backpressure: core_req is held until core_gnt; I2C accesses always win. Optional read-to-clear of the top register: I2C_ARB_RDCLR_EN.
module i2c_regbank_arb #(
    parameter int DEPTH = 16,   // power of two, 2..256
    parameter int AW    = 4     // log2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    i2c_addr,
    input  logic          i2c_wen,
    input  logic [7:0]    i2c_wdata,
    input  logic          i2c_rdata_used,
    output logic [7:0]    i2c_rdata,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [7:0]    core_wdata,
    output logic          core_gnt,
    output logic [7:0]    core_rdata,
    output logic          core_rvalid
);

    typedef enum logic [2:0] {
        G_NONE,
        G_WR,
        G_CLR,
        G_FETCH,
        G_CORE
    } grant_e;

    localparam logic [8:0] DEPTH_W   = 9'(DEPTH);
    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [7:0]    fetch_addr_q, fetch_addr_d;
    logic          fetch_valid_q, fetch_valid_d;
    logic [7:0]    i2c_rdata_q, i2c_rdata_d;
    logic [7:0]    core_rdata_q, core_rdata_d;
    logic          core_rvalid_q, core_rvalid_d;

    grant_e        grant;
    logic          i2c_in_range;
    logic [AW-1:0] i2c_idx;
    logic          fetch_hit;
    logic          clr_req;

    // Upper address bits select nothing; anything at or above DEPTH reads as zero and ignores writes.
    assign i2c_in_range = ({1'b0, i2c_addr} < DEPTH_W);
    assign i2c_idx      = i2c_addr[AW-1:0];

    // The prefetched copy is only usable while the slave still points at the same address.
    assign fetch_hit    = fetch_valid_q && (i2c_addr == fetch_addr_q);

`ifdef I2C_ARB_RDCLR_EN
    // Consuming the top register through I2C clears it.
    assign clr_req = i2c_rdata_used && (fetch_addr_q == LAST_ADDR);
`else
    logic unused_rdata_used;
    logic [7:0] unused_last_addr;
    assign unused_rdata_used = i2c_rdata_used;
    assign unused_last_addr  = LAST_ADDR;
    assign clr_req           = 1'b0;
`endif

    // Fixed-priority grant of the single storage port; nothing is granted while in reset.
    always_comb begin
        grant = G_NONE;
        if (rst) begin
            grant = G_NONE;
        end else if (i2c_wen) begin
            grant = G_WR;
        end else if (clr_req) begin
            grant = G_CLR;
        end else if (!fetch_hit) begin
            grant = G_FETCH;
        end else if (core_req) begin
            grant = G_CORE;
        end
    end

    assign core_gnt = (grant == G_CORE);

    // Next-state for storage, prefetch tracking and core read return, driven by the winning grant.
    always_comb begin
        mem_d         = mem_q;
        fetch_addr_d  = fetch_addr_q;
        fetch_valid_d = fetch_hit;
        i2c_rdata_d   = i2c_rdata_q;
        core_rdata_d  = core_rdata_q;
        core_rvalid_d = 1'b0;
        case (grant)
            G_WR: begin
                if (i2c_in_range) begin
                    mem_d[i2c_idx] = i2c_wdata;
                end
                if (i2c_addr == fetch_addr_q) begin
                    fetch_valid_d = 1'b0;
                end
            end
            G_CLR: begin
                mem_d[fetch_addr_q[AW-1:0]] = 8'h00;
                fetch_valid_d               = 1'b0;
            end
            G_FETCH: begin
                i2c_rdata_d   = i2c_in_range ? mem_q[i2c_idx] : 8'h00;
                fetch_addr_d  = i2c_addr;
                fetch_valid_d = 1'b1;
            end
            G_CORE: begin
                if (core_we) begin
                    mem_d[core_addr] = core_wdata;
                    if (8'(core_addr) == fetch_addr_q) begin
                        fetch_valid_d = 1'b0;
                    end
                end else begin
                    core_rdata_d  = mem_q[core_addr];
                    core_rvalid_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // State registers; reset aborts any access in flight and clears the whole bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            fetch_addr_q  <= 8'h00;
            fetch_valid_q <= 1'b0;
            i2c_rdata_q   <= 8'h00;
            core_rdata_q  <= 8'h00;
            core_rvalid_q <= 1'b0;
        end else begin
            mem_q         <= mem_d;
            fetch_addr_q  <= fetch_addr_d;
            fetch_valid_q <= fetch_valid_d;
            i2c_rdata_q   <= i2c_rdata_d;
            core_rdata_q  <= core_rdata_d;
            core_rvalid_q <= core_rvalid_d;
        end
    end

    assign i2c_rdata   = i2c_rdata_q;
    assign core_rdata  = core_rdata_q;
    assign core_rvalid = core_rvalid_q;

endmodule

// File: tb/tb_i2c_regbank_arb.sv
// Directed bench for i2c_regbank_arb with DEPTH=16.
// Inputs change 1ns after a rising edge; outputs are sampled away from the edge.
// Expected register contents are tracked in a small shadow array written by hand.
module tb_i2c_regbank_arb;

    logic       clk;
    logic       rst;
    logic [7:0] i2c_addr;
    logic       i2c_wen;
    logic [7:0] i2c_wdata;
    logic       i2c_rdata_used;
    logic [7:0] i2c_rdata;
    logic       core_req;
    logic       core_we;
    logic [3:0] core_addr;
    logic [7:0] core_wdata;
    logic       core_gnt;
    logic [7:0] core_rdata;
    logic       core_rvalid;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_mem [16];

    i2c_regbank_arb #(.DEPTH(16), .AW(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .i2c_addr       (i2c_addr),
        .i2c_wen        (i2c_wen),
        .i2c_wdata      (i2c_wdata),
        .i2c_rdata_used (i2c_rdata_used),
        .i2c_rdata      (i2c_rdata),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_gnt       (core_gnt),
        .core_rdata     (core_rdata),
        .core_rvalid    (core_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_wr(input string tag, input logic [3:0] a, input logic [7:0] d);
        int waited;
        waited     = 0;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = a;
        core_wdata = d;
        #1;
        while (!core_gnt && waited < 5) begin
            tick();
            waited++;
        end
        chk({tag, "_gnt"}, {31'd0, core_gnt}, 32'd1);
        tick();
        core_req = 1'b0;
        core_we  = 1'b0;
    endtask

    task automatic core_rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        int waited;
        waited    = 0;
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = a;
        #1;
        while (!core_gnt && waited < 5) begin
            tick();
            waited++;
        end
        chk({tag, "_gnt"}, {31'd0, core_gnt}, 32'd1);
        tick();
        core_req = 1'b0;
        chk({tag, "_rvalid"}, {31'd0, core_rvalid}, 32'd1);
        chk({tag, "_data"}, {24'd0, core_rdata}, {24'd0, exp});
        tick();
        chk({tag, "_rvalid_off"}, {31'd0, core_rvalid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited;
        logic [7:0] exp15;

        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        rst            = 1'b1;
        i2c_addr       = 8'h00;
        i2c_wen        = 1'b0;
        i2c_wdata      = 8'h00;
        i2c_rdata_used = 1'b0;
        core_req       = 1'b1;
        core_we        = 1'b0;
        core_addr      = 4'h0;
        core_wdata     = 8'h00;

        // Reset state, with a core request pending that must not be granted
        tick();
        tick();
        chk("rst_i2c_rdata", {24'd0, i2c_rdata}, 32'h00);
        chk("rst_core_rdata", {24'd0, core_rdata}, 32'h00);
        chk("rst_core_rvalid", {31'd0, core_rvalid}, 32'd0);
        chk("rst_core_gnt", {31'd0, core_gnt}, 32'd0);

        // Leave reset, point the slave at 0x03
        core_req = 1'b0;
        rst      = 1'b0;
        i2c_addr = 8'h03;
        tick();
        tick();
        chk("t1_rdata", {24'd0, i2c_rdata}, 32'h00);
        chk("t1_rvalid", {31'd0, core_rvalid}, 32'd0);

        // I2C write 0xA5 to 0x02 while the slave points at 0x02
        i2c_addr = 8'h02;
        tick();
        tick();
        i2c_wen   = 1'b1;
        i2c_wdata = 8'hA5;
        tick();
        i2c_wen = 1'b0;
        exp_mem[2] = 8'hA5;
        chk("t2_stale", {24'd0, i2c_rdata}, 32'h00);
        tick();
        chk("t2_refetch", {24'd0, i2c_rdata}, 32'hA5);

        // Core write to 0x05 collides with I2C write 0x5A to 0x01
        i2c_addr   = 8'h01;
        i2c_wen    = 1'b1;
        i2c_wdata  = 8'h5A;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 4'h5;
        core_wdata = 8'h3C;
        #1;
        chk("t3_gnt_blocked", {31'd0, core_gnt}, 32'd0);
        tick();
        i2c_wen = 1'b0;
        #1;
        chk("t3_gnt_fetch_cycle", {31'd0, core_gnt}, 32'd0);
        waited = 0;
        while (!core_gnt && waited < 4) begin
            tick();
            waited++;
        end
        chk("t3_gnt", {31'd0, core_gnt}, 32'd1);
        chk("t3_wait", waited, 32'd1);
        tick();
        core_req = 1'b0;
        core_we  = 1'b0;
        exp_mem[1] = 8'h5A;
        exp_mem[5] = 8'h3C;
        chk("t3_i2c_rdata", {24'd0, i2c_rdata}, 32'h5A);
        core_rd("t3_rd5", 4'h5, 8'h3C);

        // Preload 0x11/0x22/0x33 and step the slave address across them
        core_wr("t4_wr4", 4'h4, 8'h11);
        core_wr("t4_wr5", 4'h5, 8'h22);
        core_wr("t4_wr6", 4'h6, 8'h33);
        exp_mem[4] = 8'h11;
        exp_mem[5] = 8'h22;
        exp_mem[6] = 8'h33;
        i2c_addr = 8'h04;
        tick();
        chk("t4_addr4", {24'd0, i2c_rdata}, 32'h11);
        i2c_addr = 8'h05;
        tick();
        chk("t4_addr5", {24'd0, i2c_rdata}, 32'h22);
        i2c_addr = 8'h06;
        tick();
        chk("t4_addr6", {24'd0, i2c_rdata}, 32'h33);

        // Out-of-range address: write dropped, prefetch returns zero
        i2c_addr  = 8'h20;
        i2c_wen   = 1'b1;
        i2c_wdata = 8'hEE;
        tick();
        i2c_wen = 1'b0;
        tick();
        chk("t5_oor_rdata", {24'd0, i2c_rdata}, 32'h00);
        for (int i = 0; i < 16; i++) begin
            core_rd($sformatf("t5_reg%0d", i), 4'(i), exp_mem[i]);
        end

        // Read-to-clear of register 15
        core_wr("t6_wr15", 4'hF, 8'h80);
        exp_mem[15] = 8'h80;
        i2c_addr = 8'h0F;
        tick();
        chk("t6_prefetch15", {24'd0, i2c_rdata}, 32'h80);
        i2c_rdata_used = 1'b1;
        tick();
        i2c_rdata_used = 1'b0;
        tick();
`ifdef I2C_ARB_RDCLR_EN
        exp15 = 8'h00;
`else
        exp15 = 8'h80;
`endif
        exp_mem[15] = exp15;
        chk("t6_i2c_rdata15", {24'd0, i2c_rdata}, {24'd0, exp15});
        core_rd("t6_rd15", 4'hF, exp15);

        // Reset in the middle of an I2C write and a core write
        i2c_addr   = 8'h04;
        i2c_wen    = 1'b1;
        i2c_wdata  = 8'h99;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 4'h6;
        core_wdata = 8'h77;
        rst        = 1'b1;
        #1;
        chk("t7_gnt_in_rst", {31'd0, core_gnt}, 32'd0);
        tick();
        chk("t7_i2c_rdata", {24'd0, i2c_rdata}, 32'h00);
        chk("t7_core_rdata", {24'd0, core_rdata}, 32'h00);
        chk("t7_core_rvalid", {31'd0, core_rvalid}, 32'd0);
        rst      = 1'b0;
        i2c_wen  = 1'b0;
        core_req = 1'b0;
        core_we  = 1'b0;
        core_rd("t7_rd4", 4'h4, 8'h00);
        core_rd("t7_rd6", 4'h6, 8'h00);
        chk("t7_i2c_rdata4", {24'd0, i2c_rdata}, 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
